fir_coef_seq_ctrl: RTL and testbench

Sequencer that drives the shared four-bank SRAM/MAC port of the FIR filter through the module selector. It has two jobs. In update mode it streams 4 × TAPS_PER_BANK coefficients into the four single-port SRAMs, one write per cycle. In run mode, each input-sample strobe triggers a fixed read sweep over all banks with MAC enables. The block sits between the top-level FIR control inputs and the module selector; its outputs connect one-to-one to the selector's shared inputs.

---
 rtl/fir_coef_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_fir_coef_seq_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_seq_ctrl.sv
// Coefficient load / sample sweep sequencer for the four-bank FIR SRAM+MAC port.
// Drives the module selector's shared inputs; every output is a register.
module fir_coef_seq_ctrl #(
    parameter int unsigned TAPS_PER_BANK = 10
) (
    input  logic        iClk,
    input  logic        iRsn,
    input  logic        iCoeffUpdateFlag,
    input  logic        iValid,
    input  logic [15:0] iCoeff,
    output logic        oReady,
    input  logic        iEnSample,
    output logic [1:0]  oModuleSel,
    output logic        oCsnRam,
    output logic        oWrnRam,
    output logic [3:0]  oAddrRam,
    output logic [15:0] oWtDtRam,
    output logic        oEnMAC,
    output logic        oLoadDone,
    output logic        oBusy,
    output logic        oSweepDone,
    output logic        oSampleDrop
);

    typedef enum logic [1:0] {StIdle, StLoad, StLoadDone, StSweep} stateE;

    localparam logic [4:0] LastPhase = 5'(TAPS_PER_BANK);
    localparam logic [3:0] LastAddr  = 4'(TAPS_PER_BANK - 1);

    stateE      state;
    logic [1:0] bank;
    // Load: write address within bank. Sweep: phase 0..TAPS_PER_BANK (last one is the drain).
    logic [4:0] phase;
    logic [4:0] phaseInc;
    logic       transfer;

    always_comb begin
        phaseInc = phase + 5'd1;
        transfer = iValid & oReady;
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state       <= StIdle;
            bank        <= 2'd0;
            phase       <= 5'd0;
            oReady      <= 1'b0;
            oModuleSel  <= 2'd0;
            oCsnRam     <= 1'b1;
            oWrnRam     <= 1'b1;
            oAddrRam    <= 4'd0;
            oWtDtRam    <= 16'd0;
            oEnMAC      <= 1'b0;
            oLoadDone   <= 1'b0;
            oBusy       <= 1'b0;
            oSweepDone  <= 1'b0;
            oSampleDrop <= 1'b0;
        end else begin
            // Idle SRAM port and cleared pulses unless a state below overrides them.
            oModuleSel  <= 2'd0;
            oCsnRam     <= 1'b1;
            oWrnRam     <= 1'b1;
            oAddrRam    <= 4'd0;
            oWtDtRam    <= 16'd0;
            oEnMAC      <= 1'b0;
            oSweepDone  <= 1'b0;
            oSampleDrop <= 1'b0;

            unique case (state)
                StIdle: begin
                    bank  <= 2'd0;
                    phase <= 5'd0;
                    if (iCoeffUpdateFlag) begin
                        state  <= StLoad;
                        oReady <= 1'b1;
                    end else if (iEnSample) begin
                        state   <= StSweep;
                        oBusy   <= 1'b1;
                        oCsnRam <= 1'b0;
                    end
                end

                StLoad: begin
                    if (!iCoeffUpdateFlag) begin
                        // Abort: words already written stay in the SRAMs.
                        state  <= StIdle;
                        oReady <= 1'b0;
                        bank   <= 2'd0;
                        phase  <= 5'd0;
                    end else if (transfer) begin
                        oModuleSel <= bank;
                        oCsnRam    <= 1'b0;
                        oWrnRam    <= 1'b0;
                        oAddrRam   <= phase[3:0];
                        oWtDtRam   <= iCoeff;
                        if (phase[3:0] == LastAddr) begin
                            phase <= 5'd0;
                            if (bank == 2'd3) begin
                                state     <= StLoadDone;
                                bank      <= 2'd0;
                                oReady    <= 1'b0;
                                oLoadDone <= 1'b1;
                            end else begin
                                bank <= bank + 2'd1;
                            end
                        end else begin
                            phase <= phaseInc;
                        end
                    end
                end

                StLoadDone: begin
                    if (!iCoeffUpdateFlag) begin
                        state     <= StIdle;
                        oLoadDone <= 1'b0;
                    end
                end

                StSweep: begin
                    oSampleDrop <= iEnSample;
                    if (phase == LastPhase) begin
                        phase <= 5'd0;
                        if (bank == 2'd3) begin
                            state      <= StIdle;
                            bank       <= 2'd0;
                            oBusy      <= 1'b0;
                            oSweepDone <= 1'b1;
                        end else begin
                            bank       <= bank + 2'd1;
                            oModuleSel <= bank + 2'd1;
                            oCsnRam    <= 1'b0;
                        end
                    end else begin
                        // MAC lags the read by one cycle; the drain cycle only feeds the MAC.
                        phase      <= phaseInc;
                        oModuleSel <= bank;
                        oEnMAC     <= 1'b1;
                        if (phaseInc != LastPhase) begin
                            oCsnRam  <= 1'b0;
                            oAddrRam <= phaseInc[3:0];
                        end
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coef_seq_ctrl.sv
// Directed bench for fir_coef_seq_ctrl: vector tables for load traffic,
// hand-written sequences for sweep timing, collisions, async reset and a 16-tap instance.
module tb_fir_coef_seq_ctrl;

    logic        iClk = 1'b0;
    logic        iRsn = 1'b0;
    logic        flag, valid, en;
    logic [15:0] coeff;
    logic        ready, csn, wrn, enMac, loadDone, busy, sweepDone, drop;
    logic [1:0]  sel;
    logic [3:0]  addr;
    logic [15:0] wdata;

    logic        flag16, valid16, en16;
    logic [15:0] coeff16;
    logic        ready16, csn16, wrn16, enMac16, loadDone16, busy16, sweepDone16, drop16;
    logic [1:0]  sel16;
    logic [3:0]  addr16;
    logic [15:0] wdata16;

    always #5 iClk = ~iClk;

    fir_coef_seq_ctrl dut (
        .iClk(iClk), .iRsn(iRsn), .iCoeffUpdateFlag(flag), .iValid(valid), .iCoeff(coeff),
        .oReady(ready), .iEnSample(en), .oModuleSel(sel), .oCsnRam(csn), .oWrnRam(wrn),
        .oAddrRam(addr), .oWtDtRam(wdata), .oEnMAC(enMac), .oLoadDone(loadDone),
        .oBusy(busy), .oSweepDone(sweepDone), .oSampleDrop(drop)
    );

    fir_coef_seq_ctrl #(.TAPS_PER_BANK(16)) dut16 (
        .iClk(iClk), .iRsn(iRsn), .iCoeffUpdateFlag(flag16), .iValid(valid16),
        .iCoeff(coeff16), .oReady(ready16), .iEnSample(en16), .oModuleSel(sel16),
        .oCsnRam(csn16), .oWrnRam(wrn16), .oAddrRam(addr16), .oWtDtRam(wdata16),
        .oEnMAC(enMac16), .oLoadDone(loadDone16), .oBusy(busy16), .oSweepDone(sweepDone16),
        .oSampleDrop(drop16)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        flag, valid, en;
        logic [15:0] coeff;
        logic        csn, wrn;
        logic [1:0]  sel;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        ready, loadDone, busy, drop;
    } vecT;

    vecT vecs[$];

    function automatic vecT mkIdle(input logic f, input logic v, input logic e,
                                   input logic rdy, input logic ld);
        vecT r;
        r.flag = f; r.valid = v; r.en = e; r.coeff = 16'hDEAD;
        r.csn = 1'b1; r.wrn = 1'b1; r.sel = 2'd0; r.addr = 4'd0; r.data = 16'd0;
        r.ready = rdy; r.loadDone = ld; r.busy = 1'b0; r.drop = 1'b0;
        return r;
    endfunction

    function automatic vecT mkWrite(input int k, input logic [15:0] d,
                                    input logic rdy, input logic ld);
        vecT r;
        r.flag = 1'b1; r.valid = 1'b1; r.en = 1'b0; r.coeff = d;
        r.csn = 1'b0; r.wrn = 1'b0; r.sel = 2'(k / 10); r.addr = 4'(k % 10); r.data = d;
        r.ready = rdy; r.loadDone = ld; r.busy = 1'b0; r.drop = 1'b0;
        return r;
    endfunction

    // Called at a falling edge: drive a record, then check outputs after the next rising edge.
    task automatic runVecs(input string tag);
        foreach (vecs[i]) begin
            flag = vecs[i].flag; valid = vecs[i].valid; en = vecs[i].en; coeff = vecs[i].coeff;
            @(negedge iClk);
            chk($sformatf("%s[%0d].csn", tag, i), csn, vecs[i].csn);
            chk($sformatf("%s[%0d].wrn", tag, i), wrn, vecs[i].wrn);
            chk($sformatf("%s[%0d].sel", tag, i), sel, vecs[i].sel);
            chk($sformatf("%s[%0d].addr", tag, i), addr, vecs[i].addr);
            chk($sformatf("%s[%0d].data", tag, i), wdata, vecs[i].data);
            chk($sformatf("%s[%0d].ready", tag, i), ready, vecs[i].ready);
            chk($sformatf("%s[%0d].loadDone", tag, i), loadDone, vecs[i].loadDone);
            chk($sformatf("%s[%0d].busy", tag, i), busy, vecs[i].busy);
            chk($sformatf("%s[%0d].drop", tag, i), drop, vecs[i].drop);
        end
        vecs.delete();
    endtask

    // Expected pattern for sweep cycle c (1-based) at 10 taps per bank.
    task automatic chkSweep(input string tag, input int c);
        int b = (c - 1) / 11;
        int p = (c - 1) % 11;
        chk($sformatf("%s[%0d].sel", tag, c), sel, b);
        chk($sformatf("%s[%0d].csn", tag, c), csn, (p < 10) ? 0 : 1);
        chk($sformatf("%s[%0d].wrn", tag, c), wrn, 1);
        chk($sformatf("%s[%0d].addr", tag, c), addr, (p < 10) ? p : 0);
        chk($sformatf("%s[%0d].enMac", tag, c), enMac, (p >= 1) ? 1 : 0);
        chk($sformatf("%s[%0d].busy", tag, c), busy, 1);
        chk($sformatf("%s[%0d].done", tag, c), sweepDone, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        bit seen;
        int busyCnt, maxAddr, doneAt;

        flag = 0; valid = 0; en = 0; coeff = 0;
        flag16 = 0; valid16 = 0; en16 = 0; coeff16 = 0;

        #12;
        chk("rst.sel", sel, 0);       chk("rst.csn", csn, 1);     chk("rst.wrn", wrn, 1);
        chk("rst.addr", addr, 0);     chk("rst.data", wdata, 0);  chk("rst.enMac", enMac, 0);
        chk("rst.ready", ready, 0);   chk("rst.loadDone", loadDone, 0);
        chk("rst.busy", busy, 0);     chk("rst.done", sweepDone, 0);
        chk("rst.drop", drop, 0);
        @(negedge iClk);
        iRsn = 1;

        // Full load, 40 back-to-back words.
        vecs.push_back(mkIdle(1, 0, 0, 1, 0));
        for (int k = 0; k < 40; k++)
            vecs.push_back(mkWrite(k, 16'h0100 + 16'(k), (k != 39), (k == 39)));
        vecs.push_back(mkIdle(1, 1, 0, 0, 1));
        vecs.push_back(mkIdle(0, 0, 0, 0, 0));
        runVecs("load");

        // Throttled load, abort after 17 words, reload restarts at bank 0 / addr 0.
        vecs.push_back(mkIdle(1, 0, 0, 1, 0));
        w = 0;
        for (int j = 0; j < 34; j++) begin
            if (j % 2 == 0) begin
                vecs.push_back(mkWrite(w, 16'h0200 + 16'(w), 1, 0));
                w++;
            end else begin
                vecs.push_back(mkIdle(1, 0, (j == 5), 1, 0));
            end
        end
        vecs.push_back(mkIdle(0, 0, 0, 0, 0));
        vecs.push_back(mkIdle(1, 0, 1, 1, 0));
        vecs.push_back(mkWrite(0, 16'hABCD, 1, 0));
        vecs.push_back(mkIdle(0, 0, 0, 0, 0));
        vecs.push_back(mkIdle(0, 0, 0, 0, 0));
        runVecs("thr");

        // Sweep with a colliding strobe at cycle 20 and a flag raised at cycle 30.
        flag = 0; valid = 0; en = 1;
        @(negedge iClk);
        en = 0;
        for (int c = 1; c <= 44; c++) begin
            chkSweep("sweep", c);
            chk($sformatf("sweep[%0d].drop", c), drop, (c == 21) ? 1 : 0);
            chk($sformatf("sweep[%0d].ready", c), ready, 0);
            en = (c == 20);
            if (c == 30) flag = 1;
            @(negedge iClk);
        end
        chk("sweepEnd.done", sweepDone, 1);
        chk("sweepEnd.busy", busy, 0);
        chk("sweepEnd.csn", csn, 1);
        chk("sweepEnd.enMac", enMac, 0);
        chk("sweepEnd.ready", ready, 0);
        @(negedge iClk);
        chk("postSweep.ready", ready, 1);
        chk("postSweep.done", sweepDone, 0);
        chk("postSweep.busy", busy, 0);
        flag = 0;
        @(negedge iClk);
        chk("postSweep.abort", ready, 0);

        // Async reset mid-sweep at bank 2, phase 5.
        en = 1;
        @(negedge iClk);
        en = 0;
        repeat (27) @(negedge iClk);
        chk("midSweep.sel", sel, 2);
        chk("midSweep.addr", addr, 5);
        chk("midSweep.csn", csn, 0);
        chk("midSweep.enMac", enMac, 1);
        #2 iRsn = 0;
        #1;
        chk("asyncRst.csn", csn, 1);
        chk("asyncRst.enMac", enMac, 0);
        chk("asyncRst.busy", busy, 0);
        chk("asyncRst.sel", sel, 0);
        chk("asyncRst.addr", addr, 0);
        @(negedge iClk);
        iRsn = 1;
        en = 1;
        @(negedge iClk);
        en = 0;
        chk("restart.sel", sel, 0);
        chk("restart.addr", addr, 0);
        chk("restart.csn", csn, 0);
        chk("restart.busy", busy, 1);
        seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge iClk);
            if (sweepDone) seen = 1;
        end
        chk("restart.doneSeen", seen, 1);

        // 16 taps per bank: 68-cycle sweep, address reaches 15.
        en16 = 1;
        @(negedge iClk);
        en16 = 0;
        busyCnt = 0; maxAddr = 0; doneAt = 0;
        for (int c = 1; c <= 80; c++) begin
            if (busy16) busyCnt++;
            if (!csn16 && int'(addr16) > maxAddr) maxAddr = int'(addr16);
            if (sweepDone16 && doneAt == 0) doneAt = c;
            @(negedge iClk);
        end
        chk("taps16.busyCycles", busyCnt, 68);
        chk("taps16.maxAddr", maxAddr, 15);
        chk("taps16.doneCycle", doneAt, 69);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
